// File: rtl/byte_swap_arbiter.sv
// rtl/byte_swap_arbiter.sv - two-port round-robin arbiter feeding a shared byte-permute stage
// One registered output word with valid/ready; readies are combinational from valids and out_ready.
module byte_swap_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [1:0]  req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [1:0]  req1_op,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_id,
    input  logic        out_ready
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q,  out_data_d;
    logic        out_id_q,    out_id_d;
    logic        last_q,      last_d;

    logic        can_load;
    logic        grant0;
    logic        grant1;

    // Byte names: B3 = d[31:24] ... B0 = d[7:0]; result listed MSB first.
    function automatic logic [31:0] permute(input logic [31:0] d, input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00:   r = d;
            2'b01:   r = {d[7:0],   d[15:8],  d[23:16], d[31:24]};
            2'b10:   r = {d[15:8],  d[7:0],   d[31:24], d[23:16]};
            default: r = {d[23:16], d[31:24], d[7:0],   d[15:8]};
        endcase
        return r;
    endfunction

    always_comb begin
        can_load    = !out_valid_q || out_ready;

        // On contention the requester that did not win last time is granted.
        grant0      = req0_valid && (!req1_valid || last_q);
        grant1      = req1_valid && (!req0_valid || !last_q);

        req0_ready  = grant0 && can_load;
        req1_ready  = grant1 && can_load;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        last_d      = last_q;

        if (req0_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = permute(req0_data, req0_op);
            out_id_d    = 1'b0;
            last_d      = 1'b0;
        end else if (req1_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = permute(req1_data, req1_op);
            out_id_d    = 1'b1;
            last_d      = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_id_q    <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_byte_swap_arbiter.sv
// tb/tb_byte_swap_arbiter.sv - directed and randomized checks of byte_swap_arbiter against a reference model
module tb_byte_swap_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data,  req1_data;
    logic [1:0]  req0_op,    req1_op;
    logic        req0_ready, req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_ready;

    byte_swap_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Pending requester words, held until accepted.
    logic        r_valid [2];
    logic [31:0] r_data  [2];
    logic [1:0]  r_op    [2];
    logic        ord;

    // Reference model state.
    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_last;
    int          last_grant;

    function automatic logic [31:0] perm_m(input logic [31:0] w, input logic [1:0] op);
        logic [7:0]  b [4];
        int          src [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        case (op)
            2'd0:    src = '{3, 2, 1, 0};
            2'd1:    src = '{0, 1, 2, 3};
            2'd2:    src = '{1, 0, 3, 2};
            default: src = '{2, 3, 0, 1};
        endcase
        r = 32'h0;
        for (int k = 0; k < 4; k++) r = {r[23:0], b[src[k]]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_id    = 0;
        m_last  = 1;
    endtask

    // One clock: drive pending words, check readies, clock, check output register.
    task automatic run_cycle(input string tag);
        int g;
        logic can;
        req0_valid = r_valid[0]; req0_data = r_data[0]; req0_op = r_op[0];
        req1_valid = r_valid[1]; req1_data = r_data[1]; req1_op = r_op[1];
        out_ready  = ord;
        #1;
        g = -1;
        if (r_valid[0] && r_valid[1]) g = 1 - m_last;
        else if (r_valid[0])          g = 0;
        else if (r_valid[1])          g = 1;
        can = !m_valid || ord;
        check({tag, ".rdy0"}, {31'h0, req0_ready}, {31'h0, (g == 0) && can});
        check({tag, ".rdy1"}, {31'h0, req1_ready}, {31'h0, (g == 1) && can});
        @(posedge clk);
        #1;
        last_grant = -1;
        if (g >= 0 && can) begin
            m_valid    = 1'b1;
            m_data     = perm_m(r_data[g], r_op[g]);
            m_id       = g;
            m_last     = g;
            r_valid[g] = 1'b0;
            last_grant = g;
        end else if (m_valid && ord) begin
            m_valid = 1'b0;
        end
        check({tag, ".ovalid"}, {31'h0, out_valid}, {31'h0, m_valid});
        check({tag, ".odata"},  out_data, m_data);
        check({tag, ".oid"},    {31'h0, out_id}, m_id[31:0]);
    endtask

    task automatic post(input int n, input logic [31:0] d, input logic [1:0] op);
        r_valid[n] = 1'b1;
        r_data[n]  = d;
        r_op[n]    = op;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] sweep_exp [4];
        int seq [6];

        r_valid = '{1'b0, 1'b0};
        r_data  = '{32'h0, 32'h0};
        r_op    = '{2'd0, 2'd0};
        ord = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 32'h0; req1_data = 32'h0;
        req0_op = 2'd0; req1_op = 2'd0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("reset.ovalid", {31'h0, out_valid}, 32'h0);
        check("reset.odata", out_data, 32'h0);
        check("reset.oid", {31'h0, out_id}, 32'h0);
        check("reset.rdy0", {31'h0, req0_ready}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single requester
        post(0, 32'h11223344, 2'b01);
        run_cycle("single");
        check("single.const", out_data, 32'h44332211);

        // Opcode sweep on requester 1
        sweep_exp = '{32'hAABBCCDD, 32'hDDCCBBAA, 32'hCCDDAABB, 32'hBBAADDCC};
        for (int op = 0; op < 4; op++) begin
            post(1, 32'hAABBCCDD, op[1:0]);
            run_cycle("sweep");
            check("sweep.const", out_data, sweep_exp[op]);
            check("sweep.id", {31'h0, out_id}, 32'h1);
        end

        // Mid-cycle reset with a pending word
        ord = 1'b0;
        post(0, 32'hDEADBEEF, 2'b10);
        run_cycle("prerst");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.ovalid", {31'h0, out_valid}, 32'h0);
        check("midrst.odata", out_data, 32'h0);
        check("midrst.oid", {31'h0, out_id}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ord = 1'b1;

        // Contention: strict alternation starting with requester 0
        seq = '{0, 1, 0, 1, 0, 1};
        for (int c = 0; c < 6; c++) begin
            if (!r_valid[0]) post(0, 32'h01000000 + c, c[1:0]);
            if (!r_valid[1]) post(1, 32'h02000000 + (c << 8), ~c[1:0]);
            run_cycle("contend");
            check("contend.seq", {31'h0, out_id}, seq[c]);
        end
        r_valid = '{1'b0, 1'b0};

        // Backpressure
        post(0, 32'hCAFEF00D, 2'b11);
        run_cycle("bp.load");
        held = out_data;
        ord = 1'b0;
        post(0, 32'h12345678, 2'b01);
        post(1, 32'h9ABCDEF0, 2'b10);
        for (int c = 0; c < 4; c++) begin
            run_cycle("bp.hold");
            check("bp.stable", out_data, held);
        end
        ord = 1'b1;
        run_cycle("bp.release");
        check("bp.reload", {31'h0, out_valid}, 32'h1);
        r_valid = '{1'b0, 1'b0};

        // Idle drain then contention goes to the other requester
        post(1, 32'h55667788, 2'b01);
        run_cycle("drain.load");
        held = out_data;
        run_cycle("drain.idle");
        check("drain.fall", {31'h0, out_valid}, 32'h0);
        check("drain.keep", out_data, held);
        post(0, 32'hA0A1A2A3, 2'b00);
        post(1, 32'hB0B1B2B3, 2'b00);
        run_cycle("drain.next");
        check("drain.grant", {31'h0, out_id}, 32'h0);
        r_valid = '{1'b0, 1'b0};

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int n = 0; n < 2; n++)
                if (!r_valid[n] && ($urandom_range(0, 3) != 0))
                    post(n, $urandom, 2'($urandom_range(0, 3)));
            ord = ($urandom_range(0, 3) != 0);
            run_cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/byte_swap_arbiter.md
# byte_swap_arbiter

Round-robin arbiter that shares one 32-bit byte-reordering datapath between two requesters. Each request carries a word and a 2-bit swap opcode. The block grants one requester per cycle, applies the selected byte permutation and registers the result into a single-entry output stage with valid/ready handshake. It sits between the two producer ports and the downstream consumer of endian-converted words.

## Interface
- No parameters; width fixed at 32 bits, requester count fixed at 2.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a word
- req0_data  input  32  requester 0 word
- req0_op  input  2  requester 0 swap opcode
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 has a word
- req1_data  input  32  requester 1 word
- req1_op  input  2  requester 1 swap opcode
- req1_ready  output  1  requester 1 word accepted this cycle
- out_valid  output  1  output register holds a result
- out_data  output  32  permuted word
- out_id  output  1  index of the requester that produced out_data
- out_ready  input  1  consumer takes the output this cycle

## Operation
- Opcode permutations, bytes named D[31:24]=B3 … D[7:0]=B0:
  - 00: pass, output B3 B2 B1 B0
  - 01: full reverse, output B0 B1 B2 B3
  - 10: halfword swap, output B1 B0 B3 B2
  - 11: byte swap within each halfword, output B2 B3 B0 B1
- can_load = !out_valid || out_ready.
- Arbitration is combinational from req*_valid and last-grant pointer `last`:
  - only one valid: that requester is granted.
  - both valid: the requester not equal to `last` is granted.
  - neither valid: no grant.
- reqN_ready = grantN && can_load. At most one ready is high per cycle. Ready never depends on the requester's own op or data.
- Transfer on reqN_valid && reqN_ready. On that edge:
  - out_data <= permute(reqN_data, reqN_op)
  - out_id <= N
  - out_valid <= 1
  - last <= N
- Output taken (out_valid && out_ready) with no new transfer: out_valid <= 0. out_data and out_id hold their last values.
- Take and new transfer in the same cycle: the register reloads and out_valid stays 1. This gives full throughput.
- Backpressure: while out_valid && !out_ready, out_data and out_id are stable, both readies are 0, and `last` does not change.
- Requester protocol: once valid is raised, data and op are held stable until ready. The block does not check this.
- `last` changes only on a transfer. A requester that drops valid without a transfer does not move the pointer.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=32'h0, out_id=0, last=1, so requester 0 wins the first contention. req*_ready is 0 while out is empty only if no valid is present. Readies are combinational and so follow valids immediately after reset.
- Latency: a word accepted on edge k appears on out_data with out_valid=1 after edge k, visible in cycle k+1.
- Throughput: one word per cycle when out_ready is held 1.
- Fairness: with both requesters continuously valid and out_ready=1, grants strictly alternate 0,1,0,1….
- Reset mid-operation: a pending output word is discarded. The pointer returns to last=1. No partial state survives.
- Combinational paths: reqN_valid → reqN_ready and out_ready → reqN_ready. out_* are registered only.

## Test plan
- Reset: assert rst_n=0 mid-cycle with out_valid=1 → out_valid, out_data, out_id go to 0 immediately. After release, first contention grants requester 0.
- Single requester: req0 valid, data 32'h11223344, op 01, out_ready=1 → req0_ready=1. Next cycle out_data=32'h44332211, out_id=0, out_valid=1.
- Opcode sweep on requester 1 with data 32'hAABBCCDD:
  - op 00 → 32'hAABBCCDD
  - op 01 → 32'hDDCCBBAA
  - op 10 → 32'hCCDDAABB
  - op 11 → 32'hBBAADDCC
  - every result has out_id=1.
- Contention: both valid for 6 cycles, out_ready=1, distinct data → out_id sequence 0,1,0,1,0,1. Each word matches its requester and op. No drops or duplicates.
- Backpressure: load one word, hold out_ready=0 for 4 cycles with both requesters valid → both readies 0, out_data and out_id unchanged. Release out_ready → the next word loads in the same cycle the old one is taken, out_valid stays 1.
- Idle drain: one transfer, then no valids, out_ready=1 → out_valid falls after one cycle. out_data retains its value. `last` is unchanged; the next contention grants the other requester.
